// File: rtl/ecc_bank_responder_if.sv
// ecc_bank_responder_if: bank request/response bus of one ECC cache bank.
//   master : upstream mux/scrubber drives req, we, be, add, wdata
//   slave  : bank responder drives gnt, rdata, single_error, multi_error
//   A request transfers when req & gnt. rdata and the error flags belong to
//   the cycle after a read transfer.
interface ecc_bank_responder_if #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned Depth     = 2048
);
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned AddrWidth = $clog2(Depth);

    logic                 req;
    logic                 gnt;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [AddrWidth-1:0] add;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] rdata;
    logic                 single_error;
    logic                 multi_error;

    modport master (
        output req, we, be, add, wdata,
        input  gnt, rdata, single_error, multi_error
    );

    modport slave (
        input  req, we, be, add, wdata,
        output gnt, rdata, single_error, multi_error
    );
endinterface

// File: rtl/ecc_bank_responder.sv
// ecc_bank_responder: bank-side responder owning one SECDED-protected SRAM.
//   Reads return corrected data one cycle later with single/multi error
//   pulses; partial writes do read-modify-write over the corrected old word.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bank           bank request bus (slave side of ecc_bank_responder_if)
//   sram_*         SRAM macro: req/we/add/wdata out, rdata in (1 cycle latency)
// Stored word layout (systematic): {overall parity, hamming bits, data}.
//   Data bit i uses the i-th non-power-of-two as its syndrome column; check
//   bit j uses column 1<<j; the top bit makes total word parity even.
// Build option: define ECC_BANK_RESPONDER_WRITEBACK_EN to write corrected
//   words back to the SRAM after a single-error read (scrubber repair path).
module ecc_bank_responder #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned Depth     = 2048,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned ProtWidth = $clog2(DataWidth) + 2,
    parameter int unsigned SramWidth = DataWidth + ProtWidth,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ecc_bank_responder_if.slave      bank,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [AddrWidth-1:0]     sram_add_o,
    output logic [SramWidth-1:0]     sram_wdata_o,
    input  logic [SramWidth-1:0]     sram_rdata_i
);
    localparam int unsigned HamWidth = ProtWidth - 1;

    function automatic logic [DataWidth*HamWidth-1:0] gen_cols();
        logic [DataWidth*HamWidth-1:0] t;
        int unsigned k;
        t = '0;
        k = 0;
        for (int unsigned n = 3; n < (1 << HamWidth); n++) begin
            if (k < DataWidth && (n & (n - 1)) != 0) begin
                t[k*HamWidth +: HamWidth] = HamWidth'(n);
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [DataWidth*HamWidth-1:0] Cols = gen_cols();

    function automatic logic [HamWidth-1:0] ham(input logic [DataWidth-1:0] d);
        logic [HamWidth-1:0] s;
        s = '0;
        for (int i = 0; i < DataWidth; i++)
            if (d[i]) s ^= Cols[i*HamWidth +: HamWidth];
        return s;
    endfunction

    function automatic logic [SramWidth-1:0] enc(input logic [DataWidth-1:0] d);
        logic [HamWidth-1:0] s;
        s = ham(d);
        return {^{s, d}, s, d};
    endfunction

    typedef enum logic [1:0] {Idle, Resp, Merge, WriteBack} state_e;

    state_e               state;
    logic                 resp_rd;
    logic [AddrWidth-1:0] add_q;
    logic [BeWidth-1:0]   be_q;
    logic [DataWidth-1:0] wdata_q, wb_q, rdata_q;

    // decoder on the word returned by the macro
    logic [HamWidth-1:0]  syn;
    logic                 par, hit;
    logic [DataWidth-1:0] fix, dec_data, merged, enc_in;
    logic                 dec_single, dec_multi;

    always_comb begin
        syn = ham(sram_rdata_i[DataWidth-1:0]) ^ sram_rdata_i[DataWidth +: HamWidth];
        par = ^sram_rdata_i;
        hit = 1'b0;
        fix = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (syn == Cols[i*HamWidth +: HamWidth]) begin
                fix[i] = par;
                hit    = 1'b1;
            end
        end
        dec_data = sram_rdata_i[DataWidth-1:0] ^ fix;
        // odd parity with a known column (or zero / check-bit column) is one flip
        dec_single = par && (syn == '0 || $onehot(syn) || hit);
        dec_multi  = (par || syn != '0) && !dec_single;
    end

    always_comb begin
        for (int b = 0; b < BeWidth; b++)
            merged[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : dec_data[b*8 +: 8];
    end

    logic wb_pend, accept, be_full, be_none, rd_resp;

`ifdef ECC_BANK_RESPONDER_WRITEBACK_EN
    assign wb_pend = (state == Resp) && resp_rd && dec_single;
`else
    assign wb_pend = 1'b0;
`endif

    assign rd_resp  = (state == Resp) && resp_rd;
    assign bank.gnt = rst_ni && ((state == Idle) || ((state == Resp) && !wb_pend));
    assign accept   = bank.req && bank.gnt;
    assign be_full  = &bank.be;
    assign be_none  = ~|bank.be;

    assign bank.rdata        = rd_resp ? dec_data : rdata_q;
    assign bank.single_error = (rd_resp || state == Merge) && dec_single;
    assign bank.multi_error  = (rd_resp || state == Merge) && dec_multi;

    always_comb begin
        enc_in = bank.wdata;
        if (state == Merge)     enc_in = merged;
        if (state == WriteBack) enc_in = wb_q;
    end

    assign sram_wdata_o = enc(enc_in);

    always_comb begin
        sram_req_o = 1'b0;
        sram_we_o  = 1'b0;
        sram_add_o = bank.add;
        if (accept) begin
            if (!bank.we) begin
                sram_req_o = 1'b1;
            end else if (be_full) begin
                sram_req_o = 1'b1;
                sram_we_o  = 1'b1;
            end else if (!be_none) begin
                sram_req_o = 1'b1;  // fetch old word for the merge
            end
        end else if ((state == Merge && !dec_multi) || state == WriteBack) begin
            sram_req_o = 1'b1;
            sram_we_o  = 1'b1;
            sram_add_o = add_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= Idle;
            resp_rd <= 1'b0;
            add_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wb_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (rd_resp) rdata_q <= dec_data;
            case (state)
                Idle, Resp: begin
                    if (wb_pend) begin
                        state <= WriteBack;
                        wb_q  <= dec_data;
                    end else if (accept) begin
                        add_q   <= bank.add;
                        resp_rd <= !bank.we;
                        if (bank.we && !be_full && !be_none) begin
                            state   <= Merge;
                            be_q    <= bank.be;
                            wdata_q <= bank.wdata;
                        end else begin
                            state <= Resp;
                        end
                    end else begin
                        state <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_bank_responder.sv
module tb_ecc_bank_responder;
    localparam int DW = 128, DEPTH = 2048, BEW = DW / 8, AW = $clog2(DEPTH);
    localparam int PW = $clog2(DW) + 2, SW = DW + PW;
`ifdef ECC_BANK_RESPONDER_WRITEBACK_EN
    localparam bit WBEN = 1'b1;
`else
    localparam bit WBEN = 1'b0;
`endif

    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;

    ecc_bank_responder_if #(.DataWidth(DW), .Depth(DEPTH)) bif ();
    logic          sram_req, sram_we;
    logic [AW-1:0] sram_add;
    logic [SW-1:0] sram_wdata, sram_rdata;

    ecc_bank_responder #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bank(bif),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_add_o(sram_add),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    // SRAM macro with backdoor bit-flip injection
    logic [SW-1:0] mem [DEPTH];
    bit            mem_clr = 1'b1, inj_go = 1'b0;
    int            inj_a = 0;
    logic [SW-1:0] inj_mask = '0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;   // all-zero is the clean code of 0
        end else begin
            if (inj_go) mem[inj_a] <= mem[inj_a] ^ inj_mask;
            if (sram_req) begin
                if (sram_we) mem[sram_add] <= sram_wdata;
                else         sram_rdata    <= mem[sram_add];
            end
        end
    end

    // reference: logical content plus number of flips injected per word
    logic [DW-1:0] ref_data [DEPTH];
    int            ref_nf   [DEPTH];
    typedef enum int {P_NONE, P_RD, P_WR, P_MRG, P_WB} pk_t;
    pk_t           pk = P_NONE;
    int            pa = 0;
    logic [BEW-1:0] pbe = '0;
    logic [DW-1:0] pd = '0;

    bit            chk_en = 1'b0;
    bit            e_gnt = 1'b1, e_single = 1'b0, e_multi = 1'b0, e_req = 1'b0, e_wr = 1'b0;
    logic [AW-1:0] e_add = '0;
    logic [DW-1:0] e_wd = '0, m_rdata = '0;
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", bif.gnt, e_gnt);
            chk("rdata", bif.rdata, m_rdata);
            chk("single_error", bif.single_error, e_single);
            chk("multi_error", bif.multi_error, e_multi);
            chk("sram_req", sram_req, e_req);
            chk("sram_we", sram_we, e_wr);
            if (e_req) chk("sram_add", sram_add, e_add);
            if (e_wr)  chk("sram_wdata", sram_wdata[DW-1:0], e_wd);
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        for (int b = 0; b < BEW; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // one cycle: settle expectations for the pending access, then offer a request
    task automatic tick(input bit v, input bit we, input logic [BEW-1:0] be, input int a,
                        input logic [DW-1:0] d, output bit taken);
        pk_t nk;
        nk = P_NONE;
        @(posedge clk); #1;
        e_gnt = 1'b1; e_single = 1'b0; e_multi = 1'b0; e_req = 1'b0; e_wr = 1'b0;
        case (pk)
            P_RD: begin
                if (ref_nf[pa] == 0) begin
                    m_rdata = ref_data[pa];
                end else if (ref_nf[pa] == 1) begin
                    m_rdata  = ref_data[pa];
                    e_single = 1'b1;
                    if (WBEN) begin e_gnt = 1'b0; nk = P_WB; end
                end else begin
                    m_rdata = mem[pa][DW-1:0];  // uncorrected data bits
                    e_multi = 1'b1;
                end
            end
            P_MRG: begin
                e_gnt = 1'b0;
                if (ref_nf[pa] >= 2) begin
                    e_multi = 1'b1;
                end else begin
                    e_single     = (ref_nf[pa] == 1);
                    ref_data[pa] = merge(ref_data[pa], pd, pbe);
                    ref_nf[pa]   = 0;
                    e_req = 1'b1; e_wr = 1'b1; e_add = AW'(pa); e_wd = ref_data[pa];
                end
            end
            P_WB: begin
                e_gnt = 1'b0;
                e_req = 1'b1; e_wr = 1'b1; e_add = AW'(pa); e_wd = ref_data[pa];
                ref_nf[pa] = 0;
            end
            default: ;
        endcase
        taken = 1'b0;
        if (e_gnt && v) begin
            bif.req = 1'b1; bif.we = we; bif.be = be; bif.add = AW'(a); bif.wdata = d;
            taken = 1'b1;
            pa = a;
            if (!we) begin
                nk = P_RD; e_req = 1'b1; e_add = AW'(a);
            end else if (&be) begin
                nk = P_WR; e_req = 1'b1; e_wr = 1'b1; e_add = AW'(a); e_wd = d;
                ref_data[a] = d; ref_nf[a] = 0;
            end else if (be == '0) begin
                nk = P_WR;
            end else begin
                nk = P_MRG; e_req = 1'b1; e_add = AW'(a); pbe = be; pd = d;
            end
        end else begin
            // while the bank is busy a request must be ignored
            bif.req = e_gnt ? 1'b0 : 1'($urandom);
            bif.we = 1'($urandom); bif.be = BEW'($urandom); bif.add = AW'($urandom);
            bif.wdata = rnd128();
        end
        pk = nk;
    endtask

    task automatic op(input bit we, input logic [BEW-1:0] be, input int a, input logic [DW-1:0] d);
        bit t;
        t = 1'b0;
        for (int k = 0; k < 8 && !t; k++) tick(1'b1, we, be, a, d, t);
        n_chk++;
        if (!t) begin
            n_fail++;
            $display("FAIL accept: request to %0d not granted within 8 cycles", a);
        end
    endtask

    task automatic idle();
        bit t;
        tick(1'b0, 1'b0, '0, 0, '0, t);
    endtask

    task automatic quiesce();
        for (int k = 0; k < 6 && (pk != P_NONE || e_wr || e_req); k++) idle();
    endtask

    task automatic inject(input int a, input logic [SW-1:0] mask);
        quiesce();
        inj_a = a; inj_mask = mask; inj_go = 1'b1;
        idle();
        inj_go = 1'b0;
        ref_nf[a] = ref_nf[a] + $countones(mask);
    endtask

    logic [DW-1:0] ones;
    initial begin
        for (int i = 0; i < DEPTH; i++) begin ref_data[i] = '0; ref_nf[i] = 0; end
        ones = '1;
        // request held during reset must not reach the SRAM
        bif.req = 1'b1; bif.we = 1'b0; bif.be = '0; bif.add = '0; bif.wdata = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        mem_clr = 1'b0;
        #1;
        chk("rst_rdata", bif.rdata, '0);
        chk("rst_single", bif.single_error, 1'b0);
        chk("rst_multi", bif.multi_error, 1'b0);
        chk("rst_sram_req", sram_req, 1'b0);
        chk("rst_sram_we", sram_we, 1'b0);
        bif.req = 1'b0;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // clean read
        op(1'b1, '1, 5, {16{8'hA5}});
        op(1'b0, '0, 5, '0);
        idle();
        @(negedge clk);
        chk("lit_a5_rdata", bif.rdata, {16{8'hA5}});
        chk("lit_a5_single", bif.single_error, 1'b0);

        // single flip at bit 3
        op(1'b1, '1, 7, 128'h1234);
        inject(7, SW'(8));
        op(1'b0, '0, 7, '0);
        idle();
        @(negedge clk);
        chk("lit_1234_rdata", bif.rdata, 128'h1234);
        chk("lit_1234_single", bif.single_error, 1'b1);
        idle(); idle();
        op(1'b0, '0, 7, '0);
        idle();
        @(negedge clk);
        chk("lit_reread_single", bif.single_error, !WBEN);

        // double flip, then a partial write over it
        op(1'b1, '1, 9, rnd128());
        inject(9, (SW'(1) << 130) | SW'(1));
        op(1'b0, '0, 9, '0);
        idle();
        @(negedge clk);
        chk("lit_dbl_multi", bif.multi_error, 1'b1);
        op(1'b1, 16'h0001, 9, rnd128());
        idle();
        @(negedge clk);
        chk("lit_mrg_multi", bif.multi_error, 1'b1);
        chk("lit_mrg_nowrite", sram_we, 1'b0);

        // partial write over all-ones
        op(1'b1, '1, 2, ones);
        op(1'b1, 16'h000F, 2, 128'hDEADBEEF);
        idle();
        @(negedge clk);
        chk("lit_mrg_gnt", bif.gnt, 1'b0);
        idle();
        op(1'b0, '0, 2, '0);
        idle();
        @(negedge clk);
        chk("lit_merged", bif.rdata, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF});

        // back-to-back reads, then a be=0 write
        for (int a = 0; a < 4; a++) op(1'b0, '0, a, '0);
        op(1'b1, '0, 4, rnd128());
        idle(); idle();

        // reset during Merge drops the pending write
        op(1'b1, 16'h00F0, 3, rnd128());
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mrst_rdata", bif.rdata, '0);
        chk("mrst_single", bif.single_error, 1'b0);
        chk("mrst_multi", bif.multi_error, 1'b0);
        chk("mrst_sram_req", sram_req, 1'b0);
        chk("mrst_sram_we", sram_we, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        bif.req = 1'b0;
        pk = P_NONE; m_rdata = '0;
        e_gnt = 1'b1; e_single = 1'b0; e_multi = 1'b0; e_req = 1'b0; e_wr = 1'b0;
        chk_en = 1'b1;
        op(1'b0, '0, 3, '0);
        idle();

        // randomized traffic, low addresses and the top of the bank
        for (int n = 0; n < 3000; n++) begin
            int a, r;
            logic [SW-1:0] m;
            a = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 15) : $urandom_range(DEPTH-4, DEPTH-1);
            r = $urandom_range(0, 99);
            if (r < 40) begin
                op(1'b0, '0, a, '0);
            end else if (r < 65) begin
                op(1'b1, '1, a, rnd128());
            end else if (r < 85) begin
                op(1'b1, BEW'($urandom_range(1, 16'hFFFE)), a, rnd128());
            end else if (r < 90) begin
                op(1'b1, '0, a, rnd128());
            end else if (r < 95 && ref_nf[a] == 0) begin
                int b0, b1;
                b0 = $urandom_range(0, SW-1);
                m = SW'(1) << b0;
                if ($urandom_range(0, 1) == 1) begin
                    b1 = (b0 + $urandom_range(1, SW-1)) % SW;
                    m = m | (SW'(1) << b1);
                end
                inject(a, m);
            end else begin
                idle();
            end
        end
        repeat (4) idle();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
